// File: rtl/if_axis_pkg.sv
// rtl/if_axis_pkg.sv - register offsets and output stage states for the AXIS transmit bridge
package if_axis_pkg;

   // Register select values, compared against addr_i[6:4]
   localparam logic [2:0] REG_STATUS = 3'b001;
   localparam logic [2:0] REG_TXDATA = 3'b011;
   localparam logic [2:0] REG_CTRL   = 3'b100;
   localparam logic [2:0] REG_TXLAST = 3'b101;

   // Output register stage in front of the master AXIS port
   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_VALID = 1'b1
   } tx_state_t;

endpackage

// File: rtl/if_axis_fifo.sv
// rtl/if_axis_fifo.sv - synchronous FIFO with push, pop, flush and fill level
module if_axis_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             pop_ok;
   logic             push_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;
   assign pop_data = mem[rd_ptr];

   // Flush discards everything, including a push or pop in the same cycle;
   // a push into a full FIFO only lands when a pop frees a slot that cycle.
   assign pop_ok  = pop && !empty && !flush;
   assign push_ok = push && !flush && (!full || pop_ok);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_axis_tx.sv
// rtl/if_axis_tx.sv - CPU register window to AXIS master bridge; IF_AXIS_TX_TLAST_EN adds TXLAST and m_axis_tlast_o
module if_axis_tx
   import if_axis_pkg::*;
#(
   parameter logic [7:0] SOC_SEGMENT     = 8'he4,
   parameter logic [7:0] SOC_CLASS       = 8'haa,
   parameter int         AXIS_DATA_WIDTH = 8,
   parameter int         FIFO_DEPTH      = 4
) (
   input  logic                       axis_aclk_i,
   input  logic                       axis_aresetn_i,
   input  logic [31:0]                addr_i,
   input  logic [31:0]                data_i,
   input  logic                       data_w_i,
   output logic [31:0]                data_o,
   output logic                       data_access_o,
   output logic                       m_axis_tvalid_o,
   input  logic                       m_axis_tready_i,
`ifdef IF_AXIS_TX_TLAST_EN
   output logic                       m_axis_tlast_o,
`endif
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o
);

   localparam int DW = AXIS_DATA_WIDTH;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef IF_AXIS_TX_TLAST_EN
   localparam int FW = DW + 1;
`else
   localparam int FW = DW;
`endif

   logic [2:0]    reg_sel;
   logic          wr_en;
   logic          rd_en;
   logic          push_en;
   logic          flush_en;
   logic [FW-1:0] push_word;
   logic [FW-1:0] head_word;
   logic          fifo_full;
   logic          fifo_empty;
   logic [LW-1:0] fifo_level;
   logic          fifo_pop;
   logic          ovf;
   logic          ovf_evt;
   logic [31:0]   rd_value;
   tx_state_t     state;
   logic          unused_bits;

   assign data_access_o = (addr_i[31:16] == {SOC_SEGMENT, SOC_CLASS});
   assign reg_sel       = addr_i[6:4];
   assign wr_en         = data_access_o && data_w_i;
   assign rd_en         = data_access_o && !data_w_i;
   assign flush_en      = wr_en && (reg_sel == REG_CTRL) && data_i[0];
   assign unused_bits   = ^{addr_i[15:7], addr_i[3:0], data_i};

`ifdef IF_AXIS_TX_TLAST_EN
   assign push_en   = wr_en && ((reg_sel == REG_TXDATA) || (reg_sel == REG_TXLAST));
   assign push_word = {(reg_sel == REG_TXLAST), data_i[DW-1:0]};
`else
   assign push_en   = wr_en && (reg_sel == REG_TXDATA);
   assign push_word = data_i[DW-1:0];
`endif

   // The output stage pulls a new head whenever it is empty or its beat is being taken
   assign fifo_pop = ((state == TX_IDLE) || m_axis_tready_i) && !fifo_empty && !flush_en;

   // A push is lost only when the FIFO stays full this cycle; flush takes precedence
   assign ovf_evt = push_en && !flush_en && fifo_full && !fifo_pop;

   if_axis_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (axis_aclk_i),
      .rst_n     (axis_aresetn_i),
      .push      (push_en),
      .push_data (push_word),
      .pop       (fifo_pop),
      .flush     (flush_en),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Read mux; write-only and unused offsets read back as zero
   always_comb begin
      rd_value = '0;
      if (reg_sel == REG_STATUS) begin
         rd_value[0]       = fifo_full;
         rd_value[1]       = fifo_empty;
         rd_value[2]       = ovf;
         rd_value[4 +: LW] = fifo_level;
      end
   end

   // Registered read data, held between reads
   always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
      if (!axis_aresetn_i) begin
         data_o <= '0;
      end else if (rd_en) begin
         data_o <= rd_value;
      end
   end

   // Sticky overflow flag; a fresh overflow beats the clear-on-read of STATUS
   always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
      if (!axis_aresetn_i) begin
         ovf <= 1'b0;
      end else if (ovf_evt) begin
         ovf <= 1'b1;
      end else if (rd_en && (reg_sel == REG_STATUS)) begin
         ovf <= 1'b0;
      end
   end

   // Output stage FSM: holds one beat stable on the AXIS port until accepted
   always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
      if (!axis_aresetn_i) begin
         state           <= TX_IDLE;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tdata_o  <= '0;
`ifdef IF_AXIS_TX_TLAST_EN
         m_axis_tlast_o  <= 1'b0;
`endif
      end else begin
         case (state)
            TX_IDLE: begin
               if (fifo_pop) begin
                  m_axis_tdata_o  <= head_word[DW-1:0];
`ifdef IF_AXIS_TX_TLAST_EN
                  m_axis_tlast_o  <= head_word[DW];
`endif
                  m_axis_tvalid_o <= 1'b1;
                  state           <= TX_VALID;
               end
            end
            TX_VALID: begin
               if (m_axis_tready_i) begin
                  if (fifo_pop) begin
                     m_axis_tdata_o <= head_word[DW-1:0];
`ifdef IF_AXIS_TX_TLAST_EN
                     m_axis_tlast_o <= head_word[DW];
`endif
                  end else begin
                     m_axis_tvalid_o <= 1'b0;
                     state           <= TX_IDLE;
                  end
               end
            end
            default: begin
               m_axis_tvalid_o <= 1'b0;
               state           <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_axis_tx.sv
// tb/tb_if_axis_tx.sv - scoreboard bench for the AXIS transmit bridge
module tb_if_axis_tx;

   localparam logic [31:0] A_STATUS = 32'he4aa0010;
   localparam logic [31:0] A_TXDATA = 32'he4aa0030;
   localparam logic [31:0] A_CTRL   = 32'he4aa0040;
   localparam logic [31:0] A_TXLAST = 32'he4aa0050;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        wr = 1'b0;
   logic [31:0] rdata;
   logic        acc;
   logic        tvalid;
   logic        tready = 1'b0;
   logic [7:0]  tdata;
   logic        tlast;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [8:0]  exp_q[$];
   int          cyc = 0;
   int          hs_cnt = 0;
   int          first_hs = 0;
   int          last_hs = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   if_axis_tx dut (
      .axis_aclk_i     (clk),
      .axis_aresetn_i  (rst_n),
      .addr_i          (addr),
      .data_i          (wdata),
      .data_w_i        (wr),
      .data_o          (rdata),
      .data_access_o   (acc),
      .m_axis_tvalid_o (tvalid),
      .m_axis_tready_i (tready),
`ifdef IF_AXIS_TX_TLAST_EN
      .m_axis_tlast_o  (tlast),
`endif
      .m_axis_tdata_o  (tdata)
   );

`ifndef IF_AXIS_TX_TLAST_EN
   assign tlast = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard compare on handshakes, AXIS hold rule under backpressure
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_tvalid", {31'd0, tvalid}, 32'd1);
            check("hold_tdata", {24'd0, tdata}, {24'd0, prev_data});
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h expected no beat", {tlast, tdata});
            end else begin
               check("beat", {23'd0, tlast, tdata}, {23'd0, exp_q.pop_front()});
            end
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
         end
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(posedge clk);
      #1;
      wr    = 1'b0;
      addr  = '0;
   endtask

   task automatic cpu_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      wr   = 1'b0;
      @(posedge clk);
      #1;
      addr = '0;
      check(name, rdata, exp);
   endtask

   initial begin
      tick(2);
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_tdata", {24'd0, tdata}, 32'd0);
      check("rst_data_o", rdata, 32'd0);
      rst_n = 1'b1;
      tick(1);

      addr = 32'he4aa0000;
      #1 check("access_hit", {31'd0, acc}, 32'd1);
      addr = 32'he4ab0010;
      #1 check("access_miss", {31'd0, acc}, 32'd0);
      addr = '0;
      tick(1);

      // Reset while a beat is held in the output register
      tready = 1'b0;
      cpu_wr(A_TXDATA, 32'h5a);
      tick(2);
      check("pre_rst_tvalid", {31'd0, tvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_tvalid", {31'd0, tvalid}, 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      cpu_rd("status_after_rst", A_STATUS, 32'h0000_0002);

      // Single beat latency
      tready = 1'b1;
      exp_q.push_back(9'h0a5);
      cpu_wr(A_TXDATA, 32'ha5);
      check("lat_n1_tvalid", {31'd0, tvalid}, 32'd0);
      tick(1);
      check("lat_n2_tvalid", {31'd0, tvalid}, 32'd1);
      check("lat_n2_tdata", {24'd0, tdata}, 32'ha5);
      tick(1);
      check("lat_n3_tvalid", {31'd0, tvalid}, 32'd0);

      // Backpressure, full FIFO, overflow and clear-on-read
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(9'(8'h10 + i));
         cpu_wr(A_TXDATA, 32'h10 + i);
      end
      cpu_rd("status_full", A_STATUS, 32'h0000_0041);
      check("bp_tvalid", {31'd0, tvalid}, 32'd1);
      check("bp_tdata", {24'd0, tdata}, 32'h10);
      cpu_wr(A_TXDATA, 32'h15);
      cpu_rd("status_ovf", A_STATUS, 32'h0000_0045);
      cpu_rd("status_ovf_cleared", A_STATUS, 32'h0000_0041);
      tready = 1'b1;
      tick(8);
      check("bp_drained", exp_q.size(), 32'd0);

      // Streaming at one beat per cycle
      hs_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back(9'(i));
         cpu_wr(A_TXDATA, 32'(i));
      end
      tick(4);
      check("stream_beats", hs_cnt, 32'd8);
      check("stream_no_gaps", last_hs - first_hs, 32'd7);
      check("stream_drained", exp_q.size(), 32'd0);

      // Flush drops queued bytes but the held beat still completes
      tready = 1'b0;
      exp_q.push_back(9'h031);
      cpu_wr(A_TXDATA, 32'h31);
      cpu_wr(A_TXDATA, 32'h32);
      cpu_wr(A_TXDATA, 32'h33);
      cpu_wr(A_CTRL, 32'h1);
      cpu_rd("status_flushed", A_STATUS, 32'h0000_0002);
      check("flush_held_tdata", {24'd0, tdata}, 32'h31);
      tready = 1'b1;
      tick(4);
      check("flush_tvalid_low", {31'd0, tvalid}, 32'd0);
      check("flush_drained", exp_q.size(), 32'd0);

`ifdef IF_AXIS_TX_TLAST_EN
      // TLAST marking via TXDATA and TXLAST
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h122);
      cpu_wr(A_TXDATA, 32'h11);
      cpu_wr(A_TXLAST, 32'h22);
      tick(4);
      check("tlast_drained", exp_q.size(), 32'd0);
`else
      // Offset 0x50 is unused and a foreign segment is not decoded
      cpu_wr(A_TXLAST, 32'h22);
      cpu_wr(32'he4ab0030, 32'h77);
      tick(4);
      check("unused_no_beat", {31'd0, tvalid}, 32'd0);
      cpu_rd("unused_read", A_TXLAST, 32'd0);
`endif
      cpu_rd("wo_read_zero", A_TXDATA, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
